// File: rtl/celik_lab2_sys_key_pio_if.sv
// ---------------------------------------------------------------------------
// celik_lab2_sys_key_pio_if
// Avalon-MM slave bus bundle for the key PIO.
//   address    : 2-bit word address
//   chipselect : slave select, qualifies reads and writes
//   write_n    : active-low write strobe (chipselect & write_n = read)
//   writedata  : 32-bit write data
//   readdata   : 32-bit registered read data
// Modports: master (bus driver / testbench), slave (the PIO).
// ---------------------------------------------------------------------------
interface celik_lab2_sys_key_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/celik_lab2_sys_key_pio.sv
// ---------------------------------------------------------------------------
// celik_lab2_sys_key_pio
// Push-key parallel input port with per-bit edge capture and a maskable
// level interrupt, exposed as an Avalon-MM slave.
//
// Parameters:
//   WIDTH     : number of input pins / significant register bits
//   EDGE_TYPE : capture edge, 0 falling, 1 rising, 2 any
// Ports:
//   clk      : system clock, all state on rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : Avalon-MM slave (address, chipselect, write_n,
//              writedata, readdata)
//   in_port  : asynchronous key inputs (active-low, idle high)
//   irq      : active-high level interrupt, |(EDGECAP & IRQMASK)
//
// Register map: 0 DATA (ro), 1 reserved, 2 IRQMASK (rw),
//               3 EDGECAP (read, write-1-to-clear)
// ---------------------------------------------------------------------------
module celik_lab2_sys_key_pio #(
  parameter int WIDTH     = 4,
  parameter int EDGE_TYPE = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  celik_lab2_sys_key_pio_if.slave    bus,
  input  logic [WIDTH-1:0]           in_port,
  output logic                       irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] irqmask_reg;
  logic [WIDTH-1:0] edgecap_reg;
  logic [WIDTH-1:0] edgecap_next;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_bits;
  logic [31:0]      readdata_reg;
  logic [31:0]      read_mux;

  logic wr_en;
  logic rd_en;

  assign wr_en = bus.chipselect & ~bus.write_n;
  assign rd_en = bus.chipselect &  bus.write_n;

  // Per-bit edge detect and capture. Set dominates clear so an edge that
  // lands in the same cycle as a clearing write is never lost.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (EDGE_TYPE == 1) begin : g_rise
        assign edge_det[gi] = ~prev_reg[gi] & sync2_reg[gi];
      end else if (EDGE_TYPE == 2) begin : g_any
        assign edge_det[gi] = prev_reg[gi] ^ sync2_reg[gi];
      end else begin : g_fall
        assign edge_det[gi] = prev_reg[gi] & ~sync2_reg[gi];
      end

      assign clr_bits[gi] = wr_en && (bus.address == ADDR_EDGECAP) &&
                            bus.writedata[gi];

      assign edgecap_next[gi] = edge_det[gi] |
                                (edgecap_reg[gi] & ~clr_bits[gi]);
    end

    // Upper write-data bits carry no state.
    if (WIDTH < 32) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^bus.writedata[31:WIDTH];
    end
  endgenerate

  // Read mux sees register values before this edge's updates.
  always_comb begin
    read_mux = '0;
    case (bus.address)
      ADDR_DATA:    read_mux[WIDTH-1:0] = sync2_reg;
      ADDR_IRQMASK: read_mux[WIDTH-1:0] = irqmask_reg;
      ADDR_EDGECAP: read_mux[WIDTH-1:0] = edgecap_reg;
      default:      read_mux = '0;
    endcase
  end

  // Synchronizer and prev reset to all-ones: idle-high keys then produce
  // no spurious falling edge when reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg    <= '1;
      sync2_reg    <= '1;
      prev_reg     <= '1;
      irqmask_reg  <= '0;
      edgecap_reg  <= '0;
      readdata_reg <= '0;
    end else begin
      sync1_reg   <= in_port;
      sync2_reg   <= sync1_reg;
      prev_reg    <= sync2_reg;
      edgecap_reg <= edgecap_next;
      if (wr_en && (bus.address == ADDR_IRQMASK)) begin
        irqmask_reg <= bus.writedata[WIDTH-1:0];
      end
      if (rd_en) begin
        readdata_reg <= read_mux;
      end
    end
  end

  assign bus.readdata = readdata_reg;
  assign irq          = |(edgecap_reg & irqmask_reg);

endmodule

// File: tb/tb_celik_lab2_sys_key_pio.sv
// ---------------------------------------------------------------------------
// tb_celik_lab2_sys_key_pio
// Directed self-checking bench for the key PIO (WIDTH=4, falling edge).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_celik_lab2_sys_key_pio;

  logic       clk;
  logic       reset_n;
  logic [3:0] in_port;
  logic       irq;

  int check_count = 0;
  int pass_count  = 0;

  celik_lab2_sys_key_pio_if bus_if ();

  celik_lab2_sys_key_pio #(
    .WIDTH     (4),
    .EDGE_TYPE (0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave),
    .in_port (in_port),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus_if.address    = addr;
    bus_if.writedata  = data;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    tick();
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    $display("wr addr=%0d data=%h irq=%b", addr, data, irq);
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    bus_if.address    = addr;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    tick();
    bus_if.chipselect = 1'b0;
    data = bus_if.readdata;
    $display("rd addr=%0d data=%h irq=%b", addr, data, irq);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0;
    in_port = 4'hF;
    bus_if.address = 2'd0; bus_if.writedata = '0;
    bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
    ticks(2);
    check_count++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq);
    else pass_count++;
    check_count++;
    if (bus_if.readdata !== 32'h0)
      $display("FAIL reset_readdata: got %h expected 00000000", bus_if.readdata);
    else pass_count++;
    reset_n = 1'b1;
    ticks(10);
    check_count++;
    if (irq !== 1'b0) $display("FAIL idle_irq: got %b expected 0", irq);
    else pass_count++;
    bus_read(2'd3, rd);
    check_count++;
    if (rd !== 32'h0) $display("FAIL idle_edgecap: got %h expected 00000000", rd);
    else pass_count++;
    bus_read(2'd0, rd);
    check_count++;
    if (rd !== 32'h0000000F) $display("FAIL idle_data: got %h expected 0000000f", rd);
    else pass_count++;
    bus_read(2'd2, rd);
    check_count++;
    if (rd !== 32'h0) $display("FAIL idle_irqmask: got %h expected 00000000", rd);
    else pass_count++;
  endtask

  task automatic test_edge_capture();
    logic [31:0] rd;
    bus_write(2'd2, 32'h2);
    in_port = 4'hD;            // transition present at next edge k
    tick();                    // edge k
    tick();                    // edge k+1
    check_count++;
    if (irq !== 1'b0) $display("FAIL latency_early_irq: got %b expected 0", irq);
    else pass_count++;
    tick();                    // edge k+2
    check_count++;
    if (irq !== 1'b1) $display("FAIL latency_irq: got %b expected 1", irq);
    else pass_count++;
    bus_read(2'd3, rd);
    check_count++;
    if (rd !== 32'h2) $display("FAIL capture_edgecap: got %h expected 00000002", rd);
    else pass_count++;
    in_port = 4'hF;
    ticks(4);
    bus_read(2'd3, rd);
    check_count++;
    if (rd !== 32'h2) $display("FAIL sticky_edgecap: got %h expected 00000002", rd);
    else pass_count++;
    bus_read(2'd0, rd);
    check_count++;
    if (rd !== 32'hF) $display("FAIL data_after_pulse: got %h expected 0000000f", rd);
    else pass_count++;
  endtask

  task automatic test_clear();
    logic [31:0] rd;
    bus_write(2'd3, 32'h0);
    check_count++;
    if (irq !== 1'b1) $display("FAIL clear0_irq: got %b expected 1", irq);
    else pass_count++;
    bus_read(2'd3, rd);
    check_count++;
    if (rd !== 32'h2) $display("FAIL clear0_edgecap: got %h expected 00000002", rd);
    else pass_count++;
    bus_write(2'd3, 32'h2);
    check_count++;
    if (irq !== 1'b0) $display("FAIL clear1_irq: got %b expected 0", irq);
    else pass_count++;
    bus_read(2'd3, rd);
    check_count++;
    if (rd !== 32'h0) $display("FAIL clear1_edgecap: got %h expected 00000000", rd);
    else pass_count++;
  endtask

  task automatic test_mask();
    logic [31:0] rd;
    in_port = 4'hD;
    ticks(3);
    check_count++;
    if (irq !== 1'b1) $display("FAIL mask_pending_irq: got %b expected 1", irq);
    else pass_count++;
    bus_write(2'd2, 32'h0);
    check_count++;
    if (irq !== 1'b0) $display("FAIL masked_irq: got %b expected 0", irq);
    else pass_count++;
    bus_read(2'd3, rd);
    check_count++;
    if (rd !== 32'h2) $display("FAIL masked_edgecap: got %h expected 00000002", rd);
    else pass_count++;
    bus_write(2'd2, 32'h2);
    check_count++;
    if (irq !== 1'b1) $display("FAIL unmasked_irq: got %b expected 1", irq);
    else pass_count++;
    bus_write(2'd3, 32'hF);
    in_port = 4'hF;
    ticks(4);
  endtask

  task automatic test_write_ignored();
    logic [31:0] rd;
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd2, rd);
    check_count++;
    if (rd !== 32'h2) $display("FAIL ignored_wr_irqmask: got %h expected 00000002", rd);
    else pass_count++;
    bus_read(2'd1, rd);
    check_count++;
    if (rd !== 32'h0) $display("FAIL reserved_read: got %h expected 00000000", rd);
    else pass_count++;
    bus_write(2'd2, 32'hFFFF_FFF5);
    bus_read(2'd2, rd);
    check_count++;
    if (rd !== 32'h5) $display("FAIL irqmask_width: got %h expected 00000005", rd);
    else pass_count++;
  endtask

  task automatic test_same_cycle();
    logic [31:0] rd;
    bus_write(2'd2, 32'h1);
    in_port = 4'hE;
    ticks(3);
    in_port = 4'hF;
    ticks(4);
    bus_read(2'd3, rd);
    check_count++;
    if (rd !== 32'h1) $display("FAIL same_pre_edgecap: got %h expected 00000001", rd);
    else pass_count++;
    in_port = 4'hE;
    tick();                    // edge k
    tick();                    // edge k+1
    bus_write(2'd3, 32'h1);    // clear lands on edge k+2 with the capture
    check_count++;
    if (irq !== 1'b1) $display("FAIL same_irq: got %b expected 1", irq);
    else pass_count++;
    bus_read(2'd3, rd);
    check_count++;
    if (rd !== 32'h1) $display("FAIL same_edgecap: got %h expected 00000001", rd);
    else pass_count++;
    bus_write(2'd2, 32'h0);
    check_count++;
    if (irq !== 1'b0) $display("FAIL same_mask_irq: got %b expected 0", irq);
    else pass_count++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    bus_write(2'd3, 32'hF);
    in_port = 4'hF;
    ticks(4);
    in_port = 4'hA;            // falling on bits 0 and 2
    ticks(4);
    bus_write(2'd2, 32'hA);
    check_count++;
    if (irq !== 1'b0) $display("FAIL b2b_irq: got %b expected 0", irq);
    else pass_count++;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    bus_if.address    = 2'd2;
    tick();
    check_count++;
    if (bus_if.readdata !== 32'hA)
      $display("FAIL b2b_rd_irqmask: got %h expected 0000000a", bus_if.readdata);
    else pass_count++;
    bus_if.address = 2'd3;
    tick();
    check_count++;
    if (bus_if.readdata !== 32'h5)
      $display("FAIL b2b_rd_edgecap: got %h expected 00000005", bus_if.readdata);
    else pass_count++;
    bus_if.address = 2'd1;
    tick();
    check_count++;
    if (bus_if.readdata !== 32'h0)
      $display("FAIL b2b_rd_reserved: got %h expected 00000000", bus_if.readdata);
    else pass_count++;
    bus_if.address = 2'd3;
    tick();
    bus_if.chipselect = 1'b0;
    bus_if.address    = 2'd2;
    ticks(2);
    check_count++;
    if (bus_if.readdata !== 32'h5)
      $display("FAIL readdata_hold: got %h expected 00000005", bus_if.readdata);
    else pass_count++;
    $display("b2b reads done readdata=%h", bus_if.readdata);
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    bus_write(2'd2, 32'h5);
    bus_read(2'd2, rd);
    check_count++;
    if (irq !== 1'b1) $display("FAIL prereset_irq: got %b expected 1", irq);
    else pass_count++;
    #2;                        // mid-cycle, away from any edge
    reset_n = 1'b0;
    in_port = 4'hF;
    #1;
    check_count++;
    if (irq !== 1'b0) $display("FAIL async_irq: got %b expected 0", irq);
    else pass_count++;
    check_count++;
    if (bus_if.readdata !== 32'h0)
      $display("FAIL async_readdata: got %h expected 00000000", bus_if.readdata);
    else pass_count++;
    tick();
    #2;
    reset_n = 1'b1;
    ticks(5);
    check_count++;
    if (irq !== 1'b0) $display("FAIL post_reset_irq: got %b expected 0", irq);
    else pass_count++;
    bus_read(2'd3, rd);
    check_count++;
    if (rd !== 32'h0) $display("FAIL post_reset_edgecap: got %h expected 00000000", rd);
    else pass_count++;
    bus_read(2'd2, rd);
    check_count++;
    if (rd !== 32'h0) $display("FAIL post_reset_irqmask: got %h expected 00000000", rd);
    else pass_count++;
  endtask

  initial begin
    test_reset();
    test_edge_capture();
    test_clear();
    test_mask();
    test_write_ignored();
    test_same_cycle();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
